lsu_store_align: RTL and testbench
==================================

LSU_STORE_ALIGN -- requirements
Module: lsu_store_align

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of REQ-state cycles allowed without i_mem_ack (legal range 2..255).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port i_valid, input, 1, store request valid from the execute stage.
REQ-005 SHALL have port o_ready, output, 1, unit can accept a request this cycle.
REQ-006 SHALL have port i_addr, input, 32, byte address of the store.
REQ-007 SHALL have port i_data, input, 32, rs2 store data, unaligned.
REQ-008 SHALL have port i_funct3, input, 3, store width: 000 SB, 001 SH, 010 SW, all others illegal.
REQ-009 SHALL have port o_mem_req, output, 1, write request to data memory.
REQ-010 SHALL have port o_mem_addr, output, 32, word-aligned address {addr[31:2],2'b00}.
REQ-011 SHALL have port o_mem_wdata, output, 32, lane-aligned write data.
REQ-012 SHALL have port o_mem_be, output, 4, byte enables.
REQ-013 SHALL have port i_mem_ack, input, 1, memory write accepted.
REQ-014 SHALL have port o_done, output, 1, one-cycle pulse on successful completion.
REQ-015 SHALL have port o_misaligned, output, 1, one-cycle pulse on misaligned or illegal request.
REQ-016 SHALL have port o_timeout, output, 1, one-cycle pulse when the memory fails to ack.

Function
REQ-017 SHALL implement FSM states IDLE, REQ and RESP; o_ready = 1 only in IDLE.
REQ-018 SHALL accept on i_valid && o_ready, registering the aligned addr, wdata, be and an error flag in that cycle.
REQ-019 SHALL compute off = i_addr[1:0]; SB: wdata = {24'b0,d[7:0]} << 8*off, be = 4'b0001 << off.
REQ-020 SHALL compute SH: wdata = {16'b0,d[15:0]} << 8*off, be = 4'b0011 << off; SW: wdata = d, be = 4'b1111; shifted-out bits discarded.
REQ-021 SHALL flag an error for SH with off[0]=1, SW with off!=0, or illegal funct3.
REQ-022 SHALL, on an accepted error request, go IDLE->RESP, assert o_misaligned for exactly 1 cycle in RESP with o_mem_req=0, then return to IDLE.
REQ-023 SHALL, on an accepted legal request, go IDLE->REQ next cycle, driving o_mem_req=1 with stable addr/wdata/be until exit from REQ.
REQ-024 SHALL, when i_mem_ack=1 is sampled in REQ, go to RESP, deassert o_mem_req, pulse o_done for 1 cycle, then return to IDLE; minimum accept-to-done latency is 2 cycles.
REQ-025 SHALL count REQ cycles with an 8-bit counter cleared on entry; reaching TIMEOUT_CYCLES without ack SHALL drop o_mem_req, pulse o_timeout in RESP, and return to IDLE.
REQ-026 SHALL give ack priority when ack and the timeout limit coincide in the same cycle (o_done, not o_timeout).
REQ-027 SHALL ignore i_mem_ack outside REQ and ignore i_valid outside IDLE (no queuing).
REQ-028 SHALL drive o_mem_be = 0 whenever o_mem_req = 0; o_mem_addr/o_mem_wdata hold their last registered value.
REQ-029 SHALL assert at most one of o_done, o_misaligned and o_timeout in any cycle.

Reset
REQ-030 SHALL, on i_rst_n=0, immediately clear the FSM to IDLE and set o_mem_req, o_mem_be, o_done, o_misaligned, o_timeout, the counter, o_mem_addr and o_mem_wdata to 0; o_ready=1 after release.
REQ-031 SHALL abandon any in-flight request on reset mid-REQ, with no o_done or o_timeout pulse afterwards.

Verification
REQ-032 SB addr=0x1003 data=0xAABBCCDD, ack 1 cycle after req -> mem_addr=0x1000, wdata=0xDD000000, be=1000, o_done 2 cycles after accept.
REQ-033 SH addr=0x2002 data=0x12345678 -> wdata=0x56780000, be=1100; SW addr=0x3000 -> wdata=data, be=1111.
REQ-034 SW addr=0x3001 and funct3=011 -> o_mem_req never asserted, o_misaligned pulse 1 cycle after accept, o_ready high the cycle after.
REQ-035 Legal store, ack held low -> o_timeout after 16 REQ cycles; repeat with ack on the 16th cycle -> o_done only.
REQ-036 Assert i_rst_n=0 mid-REQ -> o_mem_req falls asynchronously, no completion pulse, next store completes normally.

Source files
------------

// File: rtl/lsu_store_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_store_align
//  Description : Store path of the LSU. It aligns SB/SH/SW data onto byte
//                lanes, issues one memory write and reports done,
//                misaligned or timeout as a single-cycle pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_store_align #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [2:0]  i_funct3,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    output logic        o_done,
    output logic        o_misaligned,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Counter value during the last REQ cycle that may still be acked.
    localparam logic [7:0] c_limit = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_err;
    logic        r_to;
    logic [7:0]  r_cnt;

    logic [1:0]  w_off;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_err;
    logic        w_accept;
    logic        w_at_limit;

    assign w_off      = i_addr[1:0];
    assign w_accept   = (r_state == S_IDLE) && i_valid;
    assign w_at_limit = (r_cnt == c_limit);

    // Lane alignment; bits shifted beyond the word are dropped.
    always_comb begin
        w_wdata = 32'd0;
        w_be    = 4'd0;
        w_err   = 1'b0;
        case (i_funct3)
            3'b000: begin
                w_wdata = {24'd0, i_data[7:0]} << {w_off, 3'b000};
                w_be    = 4'b0001 << w_off;
            end
            3'b001: begin
                w_wdata = {16'd0, i_data[15:0]} << {w_off, 3'b000};
                w_be    = 4'b0011 << w_off;
                w_err   = w_off[0];
            end
            3'b010: begin
                w_wdata = i_data;
                w_be    = 4'b1111;
                w_err   = (w_off != 2'b00);
            end
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_valid) w_next = w_err ? S_RESP : S_REQ;
            S_REQ:  if (i_mem_ack || w_at_limit) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= 30'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_err   <= 1'b0;
            r_to    <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= i_addr[31:2];
                r_wdata <= w_wdata;
                r_be    <= w_be;
                r_err   <= w_err;
                r_to    <= 1'b0;
                r_cnt   <= 8'd0;
            end else if (r_state == S_REQ) begin
                r_cnt <= r_cnt + 8'd1;
                // Ack wins over the limit when both land in the same cycle.
                if (!i_mem_ack && w_at_limit) r_to <= 1'b1;
            end
        end
    end

    assign o_ready      = (r_state == S_IDLE);
    assign o_mem_req    = (r_state == S_REQ);
    assign o_mem_addr   = {r_addr, 2'b00};
    assign o_mem_wdata  = r_wdata;
    assign o_mem_be     = o_mem_req ? r_be : 4'd0;
    assign o_misaligned = (r_state == S_RESP) && r_err;
    assign o_timeout    = (r_state == S_RESP) && !r_err && r_to;
    assign o_done       = (r_state == S_RESP) && !r_err && !r_to;

endmodule
`default_nettype wire

// File: tb/tb_lsu_store_align.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_lsu_store_align
//  Description : Directed self-checking bench for lsu_store_align.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_store_align;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done;
    logic        misaligned;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_store_align #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_addr       (addr),
        .i_data       (data),
        .i_funct3     (funct3),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_be     (mem_be),
        .i_mem_ack    (mem_ack),
        .o_done       (done),
        .o_misaligned (misaligned),
        .o_timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one store; ack_cyc is the cycle after accept in which ack is
    // driven high (0 = never). Cycle numbers of the pulses are returned.
    task automatic run_store(
        input  logic [2:0]  f3,
        input  logic [31:0] a,
        input  logic [31:0] d,
        input  int          ack_cyc,
        output int          done_cyc,
        output int          mis_cyc,
        output int          to_cyc,
        output int          nreq,
        output logic [31:0] wd,
        output logic [31:0] ad,
        output logic [3:0]  be,
        output int          bad
    );
        logic fin;
        done_cyc = 0; mis_cyc = 0; to_cyc = 0; nreq = 0;
        wd = 32'd0; ad = 32'd0; be = 4'd0; bad = 0; fin = 1'b0;
        @(negedge clk);
        funct3 = f3; addr = a; data = d; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int c = 1; c <= 40 && !fin; c++) begin
            mem_ack = (c == ack_cyc);
            @(negedge clk);
            if (mem_req) begin
                nreq++;
                if (nreq == 1) begin wd = mem_wdata; ad = mem_addr; be = mem_be; end
                else if (mem_wdata != wd || mem_addr != ad || mem_be != be) bad++;
            end else if (mem_be != 4'd0) bad++;
            if ((int'(done) + int'(misaligned) + int'(timeout)) > 1) bad++;
            if (done)       done_cyc = c;
            if (misaligned) mis_cyc  = c;
            if (timeout)    to_cyc   = c;
            if (done || misaligned || timeout) fin = 1'b1;
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        if (!fin) check("store_no_completion", 32'd0, 32'd1);
    endtask

    int          dc, mc, tc, nr, bd, pulses;
    logic [31:0] wd, ad;
    logic [3:0]  be;

    initial begin
        rst_n = 1'b0; valid = 1'b0; addr = 32'd0; data = 32'd0;
        funct3 = 3'd0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_req",   32'(mem_req), 32'd0);
        check("rst_be",    32'(mem_be), 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_pulses", 32'({done, misaligned, timeout}), 32'd0);

        // SB to lane 3, ack in first REQ cycle
        run_store(3'b000, 32'h0000_1003, 32'hAABB_CCDD, 1, dc, mc, tc, nr, wd, ad, be, bd);
        check("sb3_addr", ad, 32'h0000_1000);
        check("sb3_wdata", wd, 32'hDD00_0000);
        check("sb3_be", 32'(be), 32'h8);
        check("sb3_done_cyc", 32'(dc), 32'd2);
        check("sb3_nreq", 32'(nr), 32'd1);
        check("sb3_bad", 32'(bd), 32'd0);
        @(negedge clk);
        check("sb3_ready_after", 32'(ready), 32'd1);

        run_store(3'b000, 32'h0000_4001, 32'h1122_3344, 2, dc, mc, tc, nr, wd, ad, be, bd);
        check("sb1_wdata", wd, 32'h0000_4400);
        check("sb1_be", 32'(be), 32'h2);
        check("sb1_done_cyc", 32'(dc), 32'd3);
        check("sb1_nreq", 32'(nr), 32'd2);
        check("sb1_bad", 32'(bd), 32'd0);

        run_store(3'b001, 32'h0000_2002, 32'h1234_5678, 1, dc, mc, tc, nr, wd, ad, be, bd);
        check("sh2_addr", ad, 32'h0000_2000);
        check("sh2_wdata", wd, 32'h5678_0000);
        check("sh2_be", 32'(be), 32'hC);
        check("sh2_done_cyc", 32'(dc), 32'd2);

        run_store(3'b001, 32'h0000_5000, 32'hDEAD_BEEF, 3, dc, mc, tc, nr, wd, ad, be, bd);
        check("sh0_wdata", wd, 32'h0000_BEEF);
        check("sh0_be", 32'(be), 32'h3);
        check("sh0_done_cyc", 32'(dc), 32'd4);

        run_store(3'b010, 32'h0000_3000, 32'hCAFE_F00D, 1, dc, mc, tc, nr, wd, ad, be, bd);
        check("sw_addr", ad, 32'h0000_3000);
        check("sw_wdata", wd, 32'hCAFE_F00D);
        check("sw_be", 32'(be), 32'hF);
        check("sw_done_cyc", 32'(dc), 32'd2);

        // Error cases: misaligned SW, misaligned SH, illegal funct3
        run_store(3'b010, 32'h0000_3001, 32'h1111_1111, 1, dc, mc, tc, nr, wd, ad, be, bd);
        check("swmis_nreq", 32'(nr), 32'd0);
        check("swmis_cyc", 32'(mc), 32'd1);
        check("swmis_done", 32'(dc), 32'd0);
        check("swmis_bad", 32'(bd), 32'd0);
        @(negedge clk);
        check("swmis_ready_after", 32'(ready), 32'd1);

        run_store(3'b001, 32'h0000_2001, 32'h2222_2222, 1, dc, mc, tc, nr, wd, ad, be, bd);
        check("shmis_nreq", 32'(nr), 32'd0);
        check("shmis_cyc", 32'(mc), 32'd1);

        run_store(3'b011, 32'h0000_3000, 32'h3333_3333, 1, dc, mc, tc, nr, wd, ad, be, bd);
        check("ill_nreq", 32'(nr), 32'd0);
        check("ill_cyc", 32'(mc), 32'd1);
        @(negedge clk);
        check("ill_ready_after", 32'(ready), 32'd1);

        // Timeout with ack held low, then ack on the last allowed cycle
        run_store(3'b010, 32'h0000_6000, 32'h5555_AAAA, 0, dc, mc, tc, nr, wd, ad, be, bd);
        check("to_nreq", 32'(nr), 32'd16);
        check("to_cyc", 32'(tc), 32'd17);
        check("to_done", 32'(dc), 32'd0);
        check("to_bad", 32'(bd), 32'd0);

        run_store(3'b010, 32'h0000_6000, 32'h5555_AAAA, 16, dc, mc, tc, nr, wd, ad, be, bd);
        check("ack16_nreq", 32'(nr), 32'd16);
        check("ack16_done", 32'(dc), 32'd17);
        check("ack16_to", 32'(tc), 32'd0);

        // Reset in the middle of REQ
        @(negedge clk);
        funct3 = 3'b010; addr = 32'h0000_7000; data = 32'h7777_7777; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_req", 32'(mem_req), 32'd0);
        check("rst_async_be", 32'(mem_be), 32'd0);
        check("rst_async_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || timeout || misaligned) pulses++;
        end
        check("rst_no_pulse", 32'(pulses), 32'd0);

        run_store(3'b000, 32'h0000_8002, 32'h0000_00A5, 1, dc, mc, tc, nr, wd, ad, be, bd);
        check("post_rst_wdata", wd, 32'h00A5_0000);
        check("post_rst_be", 32'(be), 32'h4);
        check("post_rst_done", 32'(dc), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
